// File: rtl/uart_tx_scheduler.sv
// ============================================================================
// uart_tx_scheduler
// ----------------------------------------------------------------------------
// Shares one UART transmit line between NUM_REQ byte producers.
//   - Baud tick: carry out of a free-running phase accumulator (acc += BAUD_INC).
//   - Round-robin arbiter with a per-requester valid/ready handshake.
//   - Frame sequencer: start bit, 8 data bits LSB first, [even parity], stop bit.
//
// Build option:
//   UART_TX_PARITY_EN  when defined, a PARITY state is inserted between DATA and
//                      STOP and frames are 8E1 (11 ticks). Otherwise 8N1 (10 ticks).
//
// Ports:
//   clock50    in   1          system clock (single clock domain)
//   reset_n    in   1          asynchronous active-low reset
//   req_valid  in   NUM_REQ    bit i: requester i holds a byte
//   req_data   in   8*NUM_REQ  byte of requester i at [8*i+7 : 8*i]
//   req_ready  out  NUM_REQ    one-hot, one-cycle accept pulse (only on a tick)
//   tx         out  1          serial line, idle high
//   busy       out  1          high whenever the sequencer is not idle
//   grant_id   out  3          requester owning the current/last frame
// ============================================================================
module uart_tx_scheduler #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ACC_W    = 16,
    parameter int unsigned BAUD_INC = 151
) (
    input  logic                   clock50,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx,
    output logic                   busy,
    output logic [2:0]             grant_id
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif

    localparam logic [ACC_W:0] INC_EXT     = (ACC_W+1)'(BAUD_INC);
    localparam logic [2:0]     RR_LAST_RST = 3'(NUM_REQ - 1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [2:0]       state_q, state_d;
    logic             tx_q, tx_d;
    logic [7:0]       sh_q, sh_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [2:0]       rr_last_q, rr_last_d;
    logic [2:0]       grant_id_q, grant_id_d;
`ifdef UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    // ------------------------------------------------------------------------
    // Baud tick: the accumulator never stalls; its carry is the tick.
    // ------------------------------------------------------------------------
    logic tick;

    assign {tick, acc_d} = {1'b0, acc_q} + INC_EXT;

    // ------------------------------------------------------------------------
    // Round-robin search starting just after the last winner.
    // valid is zero-extended to 8 bits so a 3-bit index is always in range.
    // ------------------------------------------------------------------------
    logic [7:0] valid_ext;
    logic       any_valid;
    logic [2:0] grant_idx;
    logic [3:0] idx;

    assign valid_ext = 8'(req_valid);

    always_comb begin
        any_valid = 1'b0;
        grant_idx = 3'd0;
        idx       = 4'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_last_q} + 4'd1 + 4'(k);
            if (idx >= 4'(NUM_REQ)) begin
                idx = idx - 4'(NUM_REQ);
            end
            if (!any_valid && valid_ext[idx[2:0]]) begin
                any_valid = 1'b1;
                grant_idx = idx[2:0];
            end
        end
    end

    // Byte of the candidate winner.
    logic [7:0] grant_data;

    always_comb begin
        grant_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == 3'(i)) begin
                grant_data = req_data[8*i +: 8];
            end
        end
    end

    // A grant is only possible on a tick while idle or at the end of a stop bit.
    logic can_grant;
    logic grant_fire;

    assign can_grant  = (state_q == ST_IDLE) || (state_q == ST_STOP);
    assign grant_fire = tick && can_grant && any_valid;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant_fire && (grant_idx == 3'(i));
        end
    end

    // ------------------------------------------------------------------------
    // Frame sequencer: every transition is qualified by tick, so each bit is
    // exactly one tick period long.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        sh_d       = sh_q;
        bit_cnt_d  = bit_cnt_q;
        rr_last_d  = rr_last_q;
        grant_id_d = grant_id_q;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif

        if (tick) begin
            case (state_q)
                ST_IDLE, ST_STOP: begin
                    if (any_valid) begin
                        sh_d       = grant_data;
                        rr_last_d  = grant_idx;
                        grant_id_d = grant_idx;
                        tx_d       = 1'b0;
                        state_d    = ST_START;
`ifdef UART_TX_PARITY_EN
                        // Capture parity now; the byte is shifted away later.
                        par_d      = ^grant_data;
`endif
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end

                ST_START: begin
                    tx_d      = sh_q[0];
                    sh_d      = {1'b0, sh_q[7:1]};
                    bit_cnt_d = 3'd0;
                    state_d   = ST_DATA;
                end

                ST_DATA: begin
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = ST_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
`endif
                    end else begin
                        tx_d      = sh_q[0];
                        sh_d      = {1'b0, sh_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end

`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    tx_d    = 1'b1;
                    state_d = ST_STOP;
                end
`endif

                default: begin
                    tx_d    = 1'b1;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            acc_q      <= '0;
            state_q    <= ST_IDLE;
            tx_q       <= 1'b1;
            sh_q       <= 8'h00;
            bit_cnt_q  <= 3'd0;
            rr_last_q  <= RR_LAST_RST;
            grant_id_q <= 3'd0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            acc_q      <= acc_d;
            state_q    <= state_d;
            tx_q       <= tx_d;
            sh_q       <= sh_d;
            bit_cnt_q  <= bit_cnt_d;
            rr_last_q  <= rr_last_d;
            grant_id_q <= grant_id_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign tx       = tx_q;
    assign busy     = (state_q != ST_IDLE);
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// ============================================================================
// tb_uart_tx_scheduler
// ----------------------------------------------------------------------------
// Directed bench for uart_tx_scheduler at default parameters. Tick timing comes
// from an independent accumulator model sharing the DUT reset; all expected
// bits/grants are hand-derived constants.
// ============================================================================
module tb_uart_tx_scheduler;

    logic        clock50 = 1'b0;
    logic        reset_n = 1'b1;
    logic [3:0]  req_valid = 4'h0;
    logic [31:0] req_data  = 32'h0;
    logic [3:0]  req_ready;
    logic        tx;
    logic        busy;
    logic [2:0]  grant_id;

    int checks   = 0;
    int failures = 0;

    uart_tx_scheduler #(
        .NUM_REQ  (4),
        .ACC_W    (16),
        .BAUD_INC (151)
    ) dut (
        .clock50   (clock50),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx        (tx),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #10 clock50 = ~clock50;

    // Reference baud accumulator: tick when acc + 151 overflows 16 bits.
    logic [15:0] m_acc;
    logic        m_tick;

    always @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) m_acc <= 16'd0;
        else          m_acc <= m_acc + 16'd151;
    end

    assign m_tick = ((32'(m_acc) + 32'd151) > 32'd65535);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next model tick cycle, capture req_ready there, then step
    // past the tick edge so tx/state reflect the update.
    task automatic next_tick(output logic [3:0] rdy);
        int n;
        n = 0;
        while (m_tick !== 1'b1 && n < 2000) begin
            @(posedge clock50);
            #1;
            n++;
        end
        check("tick_timeout", 32'(n < 2000), 32'd1);
        rdy = req_ready;
        @(posedge clock50);
        #1;
    endtask

    // Called right after the start-bit tick; checks data bits, parity, stop.
    task automatic check_frame(input logic [7:0] d, input string tag);
        logic [3:0] r;
        for (int i = 0; i < 8; i++) begin
            next_tick(r);
            check($sformatf("%s_bit%0d", tag, i), 32'(tx), 32'(d[i]));
            check($sformatf("%s_rdy%0d", tag, i), 32'(r), 32'd0);
        end
`ifdef UART_TX_PARITY_EN
        next_tick(r);
        check($sformatf("%s_parity", tag), 32'(tx), 32'(^d));
`endif
        next_tick(r);
        check($sformatf("%s_stop", tag), 32'(tx), 32'd1);
        check($sformatf("%s_stop_busy", tag), 32'(busy), 32'd1);
    endtask

    initial begin
        logic [3:0] r;
        int         order [5];

        // ---------------- 1. reset behaviour ----------------
        #5 reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock50);
            #1;
            req_valid = ~req_valid;
            req_data  = 32'hA3A2_A1A0;
            #1;
            check("rst_tx", 32'(tx), 32'd1);
            check("rst_ready", 32'(req_ready), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end
        check("rst_grant_id", 32'(grant_id), 32'd0);

        // ---------------- 2. single requester, 0x40 ----------------
        req_valid = 4'b0001;
        req_data  = 32'h0000_0040;
        reset_n   = 1'b1;
        next_tick(r);
        check("t2_ready", 32'(r), 32'b0001);
        check("t2_start", 32'(tx), 32'd0);
        check("t2_busy", 32'(busy), 32'd1);
        check("t2_grant", 32'(grant_id), 32'd0);
        check("t2_ready_pulse", 32'(req_ready), 32'd0);
        // Byte is already captured; changing the source must not matter.
        req_valid = 4'b0000;
        req_data  = 32'hFFFF_FFFF;
        check_frame(8'h40, "t2");
        next_tick(r);
        check("t2_idle_ready", 32'(r), 32'd0);
        check("t2_idle_tx", 32'(tx), 32'd1);
        check("t2_idle_busy", 32'(busy), 32'd0);

        // ---------------- 3. all requesters, round robin ----------------
        reset_n = 1'b0;
        @(posedge clock50);
        #1;
        reset_n   = 1'b1;
        req_valid = 4'b1111;
        req_data  = 32'hA3A2_A1A0;
        order     = '{0, 1, 2, 3, 0};
        for (int f = 0; f < 5; f++) begin
            next_tick(r);
            check($sformatf("t3_ready%0d", f), 32'(r), 32'd1 << order[f]);
            check($sformatf("t3_grant%0d", f), 32'(grant_id), 32'(order[f]));
            check($sformatf("t3_start%0d", f), 32'(tx), 32'd0);
            if (f == 4) req_valid = 4'b0000;
            check_frame(8'hA0 + 8'(order[f]), $sformatf("t3f%0d", f));
        end
        next_tick(r);
        check("t3_end_ready", 32'(r), 32'd0);
        check("t3_end_busy", 32'(busy), 32'd0);
        check("t3_end_tx", 32'(tx), 32'd1);

        // ---------------- 4. short valid with no tick ----------------
        req_valid = 4'b0100;
        req_data  = 32'h0077_0000;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_ready%0d", i), 32'(req_ready), 32'd0);
            @(posedge clock50);
            #1;
        end
        req_valid = 4'b0000;
        next_tick(r);
        check("t4_ready", 32'(r), 32'd0);
        check("t4_tx", 32'(tx), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);

        // ---------------- 5. reset during DATA bit 3 ----------------
        req_valid = 4'b0010;
        req_data  = 32'h0000_3700;
        next_tick(r);
        check("t5_ready", 32'(r), 32'b0010);
        check("t5_grant", 32'(grant_id), 32'd1);
        req_valid = 4'b0000;
        for (int i = 0; i < 4; i++) next_tick(r);
        check("t5_bit3", 32'(tx), 32'd0);   // 0x37 bit 3 = 0
        check("t5_busy", 32'(busy), 32'd1);
        #3 reset_n = 1'b0;
        #1;
        check("t5_abort_tx", 32'(tx), 32'd1);
        check("t5_abort_busy", 32'(busy), 32'd0);
        check("t5_abort_ready", 32'(req_ready), 32'd0);
        @(posedge clock50);
        #1;
        reset_n   = 1'b1;
        req_valid = 4'b0011;
        req_data  = 32'h0000_375A;
        next_tick(r);
        check("t5_after_ready", 32'(r), 32'b0001);
        check("t5_after_grant", 32'(grant_id), 32'd0);
        check("t5_after_start", 32'(tx), 32'd0);
        req_valid = 4'b0000;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
